// File: rtl/alu_pkg.sv
// Purpose: shared opcode, flag and FSM-state definitions for the byte-serial ALU wrapper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    // 4-bit opcode; the upper nibble of the opcode byte is never stored.
    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_NOT   = 4'd5,
        OP_SHL   = 4'd6,
        OP_SHR   = 4'd7,
        OP_INC   = 4'd8,
        OP_DEC   = 4'd9,
        OP_MUL   = 4'd10,
        OP_CMP   = 4'd11,
        OP_PASSA = 4'd12,
        OP_PASSB = 4'd13,
        OP_NAND  = 4'd14,
        OP_NOR   = 4'd15
    } alu_op_e;

    // Bit positions of the flags inside the third output byte.
    localparam int FLAG_V_BIT = 0;
    localparam int FLAG_C_BIT = 1;
    localparam int FLAG_Z_BIT = 2;
    localparam int FLAG_N_BIT = 3;

    // Packed so that {4'b0, flags} lands each flag on its FLAG_*_BIT position.
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

    typedef enum logic [3:0] {
        ST_REQ_OP,
        ST_WAIT_OP,
        ST_REQ_A,
        ST_WAIT_A,
        ST_REQ_B,
        ST_WAIT_B,
        ST_EXEC,
        ST_OUT0,
        ST_OUT1,
        ST_OUT2
    } wrap_state_e;

    function automatic logic [7:0] flags_byte(input alu_flags_t f);
        return {4'b0000, f};
    endfunction

endpackage

// File: rtl/alu_core.sv
// Purpose: 8-bit ALU, 16 opcodes, 16-bit result plus N/Z/C/V flags.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; outputs follow inputs.
// Ports: op (opcode), a/b (operands) -> result[15:0], n, z, c, v.
module alu_core
    import alu_pkg::*;
(
    input  alu_op_e     op,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] result,
    output logic        n,
    output logic        z,
    output logic        c,
    output logic        v
);

    logic [8:0]  ext;   // 9-bit add/sub; bit 8 is carry (add) or borrow (sub)
    logic [15:0] prod;

    always_comb begin
        ext    = 9'd0;
        prod   = 16'd0;
        result = 16'd0;
        c      = 1'b0;
        v      = 1'b0;
        case (op)
            OP_ADD: begin
                ext    = {1'b0, a} + {1'b0, b};
                c      = ext[8];
                v      = (a[7] == b[7]) && (ext[7] != a[7]);
                result = {7'b0, c, ext[7:0]};
            end
            OP_SUB: begin
                ext    = {1'b0, a} - {1'b0, b};
                c      = ext[8];
                v      = (a[7] != b[7]) && (ext[7] != a[7]);
                result = {7'b0, c, ext[7:0]};
            end
            OP_CMP: begin
                // Same subtraction as SUB, but only the flags survive.
                ext    = {1'b0, a} - {1'b0, b};
                c      = ext[8];
                v      = (a[7] != b[7]) && (ext[7] != a[7]);
                result = 16'd0;
            end
            OP_INC: begin
                ext    = {1'b0, a} + 9'd1;
                c      = ext[8];
                v      = ~a[7] & ext[7];
                result = {7'b0, c, ext[7:0]};
            end
            OP_DEC: begin
                ext    = {1'b0, a} - 9'd1;
                c      = ext[8];
                v      = a[7] & ~ext[7];
                result = {7'b0, c, ext[7:0]};
            end
            OP_SHL: begin
                c      = a[7];
                result = {7'b0, c, a[6:0], 1'b0};
            end
            OP_SHR: begin
                c      = a[0];
                result = {7'b0, c, 1'b0, a[7:1]};
            end
            OP_MUL: begin
                prod   = {8'b0, a} * {8'b0, b};
                c      = |prod[15:8];
                result = prod;
            end
            OP_AND:   result = {8'b0, a & b};
            OP_OR:    result = {8'b0, a | b};
            OP_XOR:   result = {8'b0, a ^ b};
            OP_NOT:   result = {8'b0, ~a};
            OP_PASSA: result = {8'b0, a};
            OP_PASSB: result = {8'b0, b};
            OP_NAND:  result = {8'b0, ~(a & b)};
            OP_NOR:   result = {8'b0, ~(a | b)};
            default:  result = 16'd0;
        endcase

        // CMP reports on the difference it discarded; MUL's zero test spans the full product.
        n = (op == OP_CMP) ? ext[7] : result[7];
        if (op == OP_MUL)
            z = (result == 16'd0);
        else if (op == OP_CMP)
            z = (a == b);
        else
            z = (result[7:0] == 8'd0);
    end

endmodule

// File: rtl/wrapper_alu.sv
// Purpose: byte-serial wrapper: fetch opcode/A/B via next_in, run alu_core, emit lo/hi/flags bytes.
// Latency: 3*(1+WAIT_CYCLES)+1 cycles from the REQ_OP edge to the first output byte; 3*(1+WAIT_CYCLES)+4 per transaction.
// Backpressure: none; the sink must take one byte per cycle while output_done is high.
// Ports: clk, rst (async active-low), data_in[7:0] -> data_out[7:0], next_in (request pulse), output_done (byte strobe).
module wrapper_alu
    import alu_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       next_in,
    output logic       output_done
);

    localparam int              CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    wrap_state_e      state;
    logic [CNT_W-1:0] wait_cnt;
    logic             wait_done;
    alu_op_e          opcode_q;
    logic [7:0]       a_q;
    logic [7:0]       b_q;
    logic [15:0]      result_q;
    alu_flags_t       flags_q;

    logic [15:0]      core_result;
    logic             core_n, core_z, core_c, core_v;

    // Opcode byte's upper nibble carries no meaning.
    logic             unused_op_hi;
    assign unused_op_hi = ^data_in[7:4];

    assign wait_done = (wait_cnt == CNT_LAST);

    alu_core u_alu_core (
        .op     (opcode_q),
        .a      (a_q),
        .b      (b_q),
        .result (core_result),
        .n      (core_n),
        .z      (core_z),
        .c      (core_c),
        .v      (core_v)
    );

    // Each state's action happens on the edge that leaves it, so next_in and
    // output_done are high during the cycle after REQ_x / OUTx respectively.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_REQ_OP;
            wait_cnt    <= '0;
            opcode_q    <= OP_ADD;
            a_q         <= 8'd0;
            b_q         <= 8'd0;
            result_q    <= 16'd0;
            flags_q     <= '0;
            data_out    <= 8'd0;
            next_in     <= 1'b0;
            output_done <= 1'b0;
        end else begin
            next_in     <= 1'b0;
            output_done <= 1'b0;
            case (state)
                ST_REQ_OP: begin
                    next_in  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ST_WAIT_OP;
                end
                ST_WAIT_OP: begin
                    if (wait_done) begin
                        opcode_q <= alu_op_e'(data_in[3:0]);
                        state    <= ST_REQ_A;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_REQ_A: begin
                    next_in  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ST_WAIT_A;
                end
                ST_WAIT_A: begin
                    if (wait_done) begin
                        a_q   <= data_in;
                        state <= ST_REQ_B;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_REQ_B: begin
                    next_in  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ST_WAIT_B;
                end
                ST_WAIT_B: begin
                    if (wait_done) begin
                        b_q   <= data_in;
                        state <= ST_EXEC;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_EXEC: begin
                    result_q <= core_result;
                    flags_q  <= '{n: core_n, z: core_z, c: core_c, v: core_v};
                    state    <= ST_OUT0;
                end
                ST_OUT0: begin
                    data_out    <= result_q[7:0];
                    output_done <= 1'b1;
                    state       <= ST_OUT1;
                end
                ST_OUT1: begin
                    data_out    <= result_q[15:8];
                    output_done <= 1'b1;
                    state       <= ST_OUT2;
                end
                ST_OUT2: begin
                    // Flags byte stays on data_out until the next OUT0.
                    data_out    <= flags_byte(flags_q);
                    output_done <= 1'b1;
                    state       <= ST_REQ_OP;
                end
                default: state <= ST_REQ_OP;
            endcase
        end
    end

endmodule

// File: tb/tb_wrapper_alu.sv
// Purpose: self-checking bench for wrapper_alu with a scoreboard and an arithmetic reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_wrapper_alu;

    localparam int W = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       next_in;
    logic       output_done;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc   = 0;
    int         last_req_cyc = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    wrapper_alu #(.WAIT_CYCLES(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .data_out    (data_out),
        .next_in     (next_in),
        .output_done (output_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    endtask

    // Reference: the opcode table evaluated with plain integer arithmetic.
    // Returns {low byte, high byte, flags byte}.
    function automatic logic [23:0] ref_model(input logic [7:0] op_byte, input logic [7:0] a, input logic [7:0] b);
        int op = int'(op_byte) % 16;
        int ua = int'(a);
        int ub = int'(b);
        int sa = $signed(a);
        int sb = $signed(b);
        int r, lo, hi, n, z, c, v;
        lo = 0; hi = 0; n = 0; z = 0; c = 0; v = 0; r = 0;
        case (op)
            0:  begin r = ua + ub; lo = r % 256; c = (r > 255); hi = c;
                      v = (sa + sb > 127) || (sa + sb < -128); end
            1:  begin lo = (ua - ub + 256) % 256; c = (ua < ub); hi = c;
                      v = (sa - sb > 127) || (sa - sb < -128); end
            2:  lo = ua & ub;
            3:  lo = ua | ub;
            4:  lo = ua ^ ub;
            5:  lo = 255 - ua;
            6:  begin lo = (ua * 2) % 256; c = ua / 128; hi = c; end
            7:  begin lo = ua / 2; c = ua % 2; hi = c; end
            8:  begin lo = (ua + 1) % 256; c = (ua == 255); hi = c; v = (sa + 1 > 127); end
            9:  begin lo = (ua + 255) % 256; c = (ua == 0); hi = c; v = (sa - 1 < -128); end
            10: begin r = ua * ub; lo = r % 256; hi = r / 256; c = (hi != 0); z = (r == 0); end
            11: begin lo = 0; hi = 0; n = ((ua - ub + 256) % 256) / 128; z = (ua == ub);
                      c = (ua < ub); v = (sa - sb > 127) || (sa - sb < -128); end
            12: lo = ua;
            13: lo = ub;
            14: lo = 255 - (ua & ub);
            default: lo = 255 - (ua | ub);
        endcase
        if (op != 11) n = lo / 128;
        if (op != 10 && op != 11) z = (lo == 0);
        return {8'(lo), 8'(hi), 8'(n * 8 + z * 4 + c * 2 + v)};
    endfunction

    function automatic logic [7:0] pick();
        case ($urandom_range(0, 5))
            0:       return 8'h00;
            1:       return 8'h7F;
            2:       return 8'h80;
            3:       return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    // Wait for a request pulse, answer it, and check the pulse is one cycle wide.
    task automatic serve(input int k, input logic [7:0] b);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (next_in !== 1'b1 && n < 40);
        if (next_in !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL next_in_timeout: next_in stayed low for %0d cycles, expected a pulse", n);
            finish_run();
        end
        if (k > 0) chk($sformatf("req_gap%0d", k), 32'(cyc - last_req_cyc), 32'(1 + W));
        last_req_cyc = cyc;
        data_in = b;
        @(negedge clk);
        chk("next_in_width", 32'(next_in), 32'd0);
    endtask

    task automatic run_txn(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [23:0] e;
        serve(0, op);
        serve(1, a);
        serve(2, b);
        e = ref_model(op, a, b);
        exp_q.push_back(e[23:16]);
        exp_q.push_back(e[15:8]);
        exp_q.push_back(e[7:0]);
    endtask

    // Monitor: pops the scoreboard whenever a byte is strobed.
    initial begin
        int         run = 0;
        int         idx = 0;
        logic [7:0] hold = 8'h00;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                chk("rst_data_out", 32'(data_out), 32'd0);
                chk("rst_output_done", 32'(output_done), 32'd0);
                chk("rst_next_in", 32'(next_in), 32'd0);
                run  = 0;
                idx  = 0;
                hold = 8'h00;
            end else if (output_done === 1'b1) begin
                run++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got byte 0x%0h, expected no output", data_out);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("out_byte%0d", idx), 32'(data_out), 32'(e));
                    if (idx == 2) hold = e;
                    idx = (idx + 1) % 3;
                end
            end else begin
                if (run != 0) begin
                    chk("done_burst_len", 32'(run), 32'd3);
                    run = 0;
                end
                chk("hold_data_out", 32'(data_out), 32'(hold));
            end
        end
    end

    initial begin
        #200000;
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        finish_run();
    end

    initial begin
        int n;
        rst     = 1'b1;
        data_in = 8'h00;
        #1 rst  = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;

        // Incrementing source: op=1 (SUB), A=2, B=3.
        run_txn(8'h01, 8'h02, 8'h03);
        run_txn(8'h00, 8'h7F, 8'h01);
        run_txn(8'h00, 8'hFF, 8'h01);
        run_txn(8'h0A, 8'h10, 8'h10);
        run_txn(8'h0A, 8'h00, 8'h55);
        run_txn(8'h06, 8'h81, 8'($urandom));
        run_txn(8'h07, 8'h81, 8'($urandom));
        run_txn(8'h0B, 8'h33, 8'h33);
        run_txn(8'hFC, 8'hA5, 8'($urandom));

        // Abort during WAIT_B: B has been requested but not yet latched.
        serve(0, 8'h00);
        serve(1, 8'h12);
        serve(2, 8'h34);
        #2 rst = 1'b0;
        #1;
        chk("abort_data_out", 32'(data_out), 32'd0);
        chk("abort_output_done", 32'(output_done), 32'd0);
        chk("abort_next_in", 32'(next_in), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        run_txn(8'h04, 8'hF0, 8'h3C);
        for (int i = 0; i < 40; i++) begin
            run_txn(8'($urandom), pick(), pick());
        end

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d bytes still pending, expected 0", exp_q.size());
        end
        repeat (3) @(negedge clk);
        finish_run();
    end

endmodule
